// File: rtl/sprite_draw_unit.sv
// Sprite blitter: scans one sprite frame out of a synchronous ROM and issues clipped,
// colour-keyed VGA plots, then pulses done. Define SPRITE_MIRROR_EN to honour mirror_i.
module sprite_draw_unit #(
    parameter int SPRITE_W    = 16,
    parameter int SPRITE_H    = 16,
    parameter int FRAMES      = 4,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int COLOUR_W    = 3,
    parameter int TRANSPARENT = 0,
    parameter int ADDR_W      = 10
) (
    input  logic                clock_i,
    input  logic                reset_i,      // asynchronous, active low
    input  logic                draw_i,
    input  logic [8:0]          pos_x_i,
    input  logic [7:0]          pos_y_i,
    input  logic [1:0]          frame_sel_i,
    input  logic                mirror_i,
    output logic [ADDR_W-1:0]   rom_addr_o,
    input  logic [COLOUR_W-1:0] rom_data_i,
    output logic [8:0]          vga_x_o,
    output logic [7:0]          vga_y_o,
    output logic [COLOUR_W-1:0] vga_colour_o,
    output logic                vga_plot_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int  FRAME_PIX = SPRITE_W * SPRITE_H;
    localparam int  PX_W      = $clog2(SPRITE_W);
    localparam int  PY_W      = $clog2(SPRITE_H);
    // An undersized ROM address would alias frames onto each other; such a build never starts.
    localparam bit  ADDR_W_OK = ADDR_W >= $clog2(FRAMES * FRAME_PIX);

    typedef enum logic [2:0] {IDLE, SCAN, FLUSH1, FLUSH2, DONE, RELEASE} state_e;

    state_e state_q, state_d;

    logic [8:0]          pos_x_q;
    logic [7:0]          pos_y_q;
    logic [1:0]          frame_q;
    logic [PX_W-1:0]     px_q, px1_q, px2_q, col;
    logic [PY_W-1:0]     py_q, py1_q, py2_q;
    logic                addr_vld_q, data_vld_q;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [8:0]          vga_x_q;
    logic [7:0]          vga_y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q, done_q;

    logic       busy, start, fire, abort, last_px, last_py, on_screen, opaque;
    logic [9:0] x_sum;
    logic [8:0] y_sum;

    assign busy    = (state_q == SCAN) || (state_q == FLUSH1) || (state_q == FLUSH2);
    assign start   = (state_q == IDLE) && draw_i && ADDR_W_OK;
    assign fire    = (state_q == SCAN) && draw_i;
    assign abort   = busy && !draw_i;
    assign last_px = px_q == PX_W'(SPRITE_W - 1);
    assign last_py = py_q == PY_W'(SPRITE_H - 1);

`ifdef SPRITE_MIRROR_EN
    logic mirror_q;
    assign col = mirror_q ? PX_W'(SPRITE_W - 1) - px_q : px_q;
`else
    logic unused_mirror;
    assign unused_mirror = mirror_i;
    assign col           = px_q;
`endif

    assign rom_addr_d = ADDR_W'(int'(frame_q) * FRAME_PIX + int'(py_q) * SPRITE_W + int'(col));

    // Screen position is computed one bit wider so off-screen pixels clip instead of wrapping.
    assign x_sum     = {1'b0, pos_x_q} + 10'(px2_q);
    assign y_sum     = {1'b0, pos_y_q} + 9'(py2_q);
    assign on_screen = (x_sum < 10'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));
    assign opaque    = rom_data_i != COLOUR_W'(TRANSPARENT);

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SCAN;
            SCAN:    if (!draw_i) state_d = IDLE;
                     else if (last_px && last_py) state_d = FLUSH1;
            FLUSH1:  state_d = draw_i ? FLUSH2 : IDLE;
            FLUSH2:  state_d = draw_i ? DONE : IDLE;
            DONE:    state_d = RELEASE;
            RELEASE: if (!draw_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every pipeline stage sampling last cycle's values.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            frame_q    <= '0;
            px_q       <= '0;
            py_q       <= '0;
            px1_q      <= '0;
            py1_q      <= '0;
            px2_q      <= '0;
            py2_q      <= '0;
            addr_vld_q <= 1'b0;
            data_vld_q <= 1'b0;
            rom_addr_q <= '0;
            vga_x_q    <= '0;
            vga_y_q    <= '0;
            colour_q   <= '0;
            plot_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            mirror_q   <= 1'b0;
`endif
        end else begin
            if (start) begin
                pos_x_q  <= pos_x_i;
                pos_y_q  <= pos_y_i;
                frame_q  <= frame_sel_i;
                px_q     <= '0;
                py_q     <= '0;
`ifdef SPRITE_MIRROR_EN
                mirror_q <= mirror_i;
`endif
            end
            if (fire) begin
                rom_addr_q <= rom_addr_d;
                px1_q      <= px_q;
                py1_q      <= py_q;
                px_q       <= last_px ? '0 : px_q + PX_W'(1);
                if (last_px) py_q <= py_q + PY_W'(1);
            end
            addr_vld_q <= fire;
            data_vld_q <= addr_vld_q && !abort;
            px2_q      <= px1_q;
            py2_q      <= py1_q;
            vga_x_q    <= x_sum[8:0];
            vga_y_q    <= y_sum[7:0];
            colour_q   <= rom_data_i;
            plot_q     <= data_vld_q && !abort && opaque && on_screen;
            // Registered from DONE so the pulse lands after the final plot, never alongside it.
            done_q     <= state_q == DONE;
        end
    end

    assign rom_addr_o   = rom_addr_q;
    assign vga_x_o      = vga_x_q;
    assign vga_y_o      = vga_y_q;
    assign vga_colour_o = colour_q;
    assign vga_plot_o   = plot_q;
    assign busy_o       = busy;
    assign done_o       = done_q;

endmodule

// File: tb/tb_sprite_draw_unit.sv
// Self-checking bench for sprite_draw_unit: table-driven passes, abort/reset/hold sequences,
// and random passes, all compared against a per-pixel reference model of the sprite scan.
module tb_sprite_draw_unit;

    localparam int W = 16;
    localparam int H = 16;
    localparam int N = W * H;
`ifdef SPRITE_MIRROR_EN
    localparam bit MIRROR_ON = 1'b1;
`else
    localparam bit MIRROR_ON = 1'b0;
`endif

    typedef struct {
        int cyc;
        int x;
        int y;
        int c;
    } plot_t;

    typedef struct {
        string name;
        int    px;
        int    py;
        int    fr;
        int    mir;
        int    pat;
        int    exp_cnt;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       draw = 1'b0;
    logic       mirror = 1'b0;
    logic [8:0] pos_x = '0;
    logic [7:0] pos_y = '0;
    logic [1:0] frame_sel = '0;
    logic [9:0] rom_addr;
    logic [2:0] rom_data = '0;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot, busy, done;

    logic [2:0] rom [1024];
    plot_t      exp_q[$];
    vec_t       vecs[7];
    int         checks = 0;
    int         errors = 0;

    sprite_draw_unit dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .draw_i      (draw),
        .pos_x_i     (pos_x),
        .pos_y_i     (pos_y),
        .frame_sel_i (frame_sel),
        .mirror_i    (mirror),
        .rom_addr_o  (rom_addr),
        .rom_data_i  (rom_data),
        .vga_x_o     (vga_x),
        .vga_y_o     (vga_y),
        .vga_colour_o(vga_colour),
        .vga_plot_o  (vga_plot),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clock = ~clock;

    // Synchronous sprite ROM: data valid one cycle after the address.
    always @(posedge clock) rom_data <= rom[rom_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] pk(input int cyc, input int x, input int y, input int c);
        return {32'(cyc), 16'(x), 8'(y), 8'(c)};
    endfunction

    task automatic fill_rom(input int pat);
        for (int a = 0; a < 1024; a++) begin
            case (pat)
                0:       rom[a] = 3'(a % 7 + 1);
                1:       rom[a] = (a % W == 0) ? 3'd0 : 3'(a % 7 + 1);
                default: rom[a] = 3'($urandom_range(0, 7));
            endcase
        end
    endtask

    // Expected plots in scan order, each tagged with the cycle it should appear in.
    task automatic build_model(input int pxs, input int pys, input int fr, input int mir);
        exp_q.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int col = (MIRROR_ON && mir != 0) ? W - 1 - x : x;
                int c   = int'(rom[fr * N + y * W + col]);
                if (c != 0 && pxs + x < 320 && pys + y < 240)
                    exp_q.push_back('{3 + y * W + x, pxs + x, pys + y, c});
            end
        end
    endtask

    task automatic run_pass(input string tag, input int pxs, input int pys, input int fr,
                            input int mir, input int exp_cnt);
        plot_t e;
        int    plots = 0;
        int    dones = 0;
        int    done_cyc = -1;
        int    amin = 1 << 30;
        int    amax = -1;
        int    model_cnt;
        logic  stray = 1'b0;
        build_model(pxs, pys, fr, mir);
        model_cnt = exp_q.size();
        pos_x = 9'(pxs);
        pos_y = 8'(pys);
        frame_sel = 2'(fr);
        mirror = 1'(mir);
        draw = 1'b1;
        step();
        // Inputs other than draw must be ignored once the pass has started.
        pos_x = 9'($urandom);
        pos_y = 8'($urandom);
        frame_sel = 2'($urandom);
        mirror = 1'($urandom);
        for (int cyc = 1; cyc <= N + 5; cyc++) begin
            step();
            if (cyc == 1) begin
                check({tag, " first_addr"}, 64'(rom_addr),
                      64'(fr * N + ((MIRROR_ON && mir != 0) ? W - 1 : 0)));
                check({tag, " busy"}, 64'(busy), 64'(1));
            end
            if (cyc <= N) begin
                if (int'(rom_addr) < amin) amin = int'(rom_addr);
                if (int'(rom_addr) > amax) amax = int'(rom_addr);
            end
            if (vga_plot) begin
                plots++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({tag, " plot"}, pk(cyc, int'(vga_x), int'(vga_y), int'(vga_colour)),
                          pk(e.cyc, e.x, e.y, e.c));
                end else begin
                    check({tag, " extra_plot"}, pk(cyc, int'(vga_x), int'(vga_y), int'(vga_colour)),
                          '1);
                end
            end
            if (done) begin
                dones++;
                done_cyc = cyc;
                check({tag, " done_with_plot"}, 64'(vga_plot), 64'(0));
            end
        end
        check({tag, " plot_count_model"}, 64'(plots), 64'(model_cnt));
        if (exp_cnt >= 0) check({tag, " plot_count"}, 64'(plots), 64'(exp_cnt));
        check({tag, " done_count"}, 64'(dones), 64'(1));
        check({tag, " done_cycle"}, 64'(done_cyc), 64'(N + 3));
        check({tag, " addr_min"}, 64'(amin), 64'(fr * N));
        check({tag, " addr_max"}, 64'(amax), 64'(fr * N + N - 1));
        for (int i = 0; i < 20; i++) begin
            step();
            stray |= busy | vga_plot | done;
        end
        check({tag, " held_draw_no_repass"}, 64'(stray), 64'(0));
        draw = 1'b0;
        step();
    endtask

    initial begin
        int   plots;
        logic stray;

        vecs[0] = '{"ramp",       100,  50, 0, 0, 0, 256};
        vecs[1] = '{"col0_clear", 100,  50, 0, 0, 1, 240};
        vecs[2] = '{"col0_f2",    100,  50, 2, 0, 1, 240};
        vecs[3] = '{"clip_corner",310, 230, 1, 0, 0, 100};
        vecs[4] = '{"mirror_org",   0,   0, 0, 1, 0, 256};
        vecs[5] = '{"one_pixel",  319, 239, 3, 0, 0,   1};
        vecs[6] = '{"clip_right", 305,   0, 0, 0, 0, 240};

        fill_rom(0);
        repeat (3) step();
        check("reset_outputs", 64'({rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done}), 64'(0));
        #2 reset = 1'b1;
        step();

        foreach (vecs[i]) begin
            fill_rom(vecs[i].pat);
            run_pass(vecs[i].name, vecs[i].px, vecs[i].py, vecs[i].fr, vecs[i].mir, vecs[i].exp_cnt);
        end

        // Abort: drop draw in cycle 40, nothing plots afterwards and done never fires.
        fill_rom(0);
        plots = 0;
        stray = 1'b0;
        pos_x = 9'd100;
        pos_y = 8'd50;
        frame_sel = 2'd0;
        mirror = 1'b0;
        draw = 1'b1;
        step();
        for (int cyc = 1; cyc <= 40; cyc++) begin
            step();
            if (vga_plot) plots++;
        end
        check("abort plots_before", 64'(plots), 64'(38));
        draw = 1'b0;
        step();
        check("abort busy_next", 64'(busy), 64'(0));
        for (int i = 0; i < 20; i++) begin
            stray |= vga_plot | done;
            step();
        end
        check("abort quiet", 64'(stray), 64'(0));
        run_pass("restart", 100, 50, 0, 0, 256);

        // Asynchronous reset mid-pass.
        pos_x = 9'd100;
        pos_y = 8'd50;
        frame_sel = 2'd1;
        draw = 1'b1;
        step();
        for (int cyc = 1; cyc <= 100; cyc++) step();
        check("pre_reset busy", 64'(busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("async_reset outputs",
              64'({rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done}), 64'(0));
        draw = 1'b0;
        repeat (2) step();
        #3 reset = 1'b1;
        repeat (3) step();
        check("post_reset idle", 64'({busy, vga_plot, done, rom_addr}), 64'(0));
        run_pass("after_reset", 100, 50, 0, 0, 256);

        for (int r = 0; r < 4; r++) begin
            fill_rom(2);
            run_pass($sformatf("random%0d", r), $urandom_range(0, 340), $urandom_range(0, 250),
                     $urandom_range(0, 3), $urandom_range(0, 1), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
